// File: rtl/gate_response_checker_pkg.sv
// gate_response_checker_pkg: opcode and FSM state encodings shared by the gate checker blocks
package gate_response_checker_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden result for the logic-gate opcodes (reserved op yields 0)
module gate_ref_model
  import gate_response_checker_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);
  always_comb begin
    expected = '0;
    case (op)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      OP_XNOR: expected = ~(a ^ b);
      OP_NAND: expected = ~(a & b);
      OP_NOR:  expected = ~(a | b);
      OP_NOT:  expected = ~a;
      default: expected = '0;
    endcase
  end
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: recomputes gate results, tallies pass/fail and captures the first mismatch.
// Optional HALT_ON_FAIL_EN: the first mismatch ends the run early.
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_result,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_exp
);
  state_t state, state_n;
  logic [CNT_W-1:0] idx, n_lat, p_idx;
  logic [WIDTH-1:0] exp_c, p_exp, p_dut;
  logic p_valid, p_rsvd, p_fail, xfer, last, go, halt;
  gate_ref_model #(.WIDTH(WIDTH)) u_ref (.op(op), .a(a), .b(b), .expected(exp_c));
  assign in_ready = state == S_RUN;
  assign busy = state == S_RUN || state == S_DRAIN;
  assign done = state == S_DONE;
  assign xfer = in_valid && in_ready;
  assign last = idx == n_lat - 1'b1;
  assign go = start && (state == S_IDLE || state == S_DONE);
  // reserved opcode never passes, even when dut_result happens to be 0
  assign p_fail = p_valid && (p_rsvd || p_dut != p_exp);
`ifdef HALT_ON_FAIL_EN
  assign halt = p_fail;
`else
  assign halt = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: state_n = go ? (num_vectors == '0 ? S_DONE : S_RUN) : state;
      S_RUN: state_n = (xfer && last) || halt ? S_DRAIN : S_RUN;
      S_DRAIN: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      n_lat <= '0;
      p_valid <= 1'b0;
      p_rsvd <= 1'b0;
      p_exp <= '0;
      p_dut <= '0;
      p_idx <= '0;
      pass_count <= '0;
      fail_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        idx <= '0;
        n_lat <= num_vectors;
        p_valid <= 1'b0;
        pass_count <= '0;
        fail_count <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx <= '0;
        first_fail_exp <= '0;
      end else begin
        p_valid <= xfer;
        if (xfer) begin
          p_exp <= exp_c;
          p_dut <= dut_result;
          p_idx <= idx;
          p_rsvd <= op == OP_RSVD;
          idx <= idx + 1'b1;
        end
        if (p_valid && !p_fail && pass_count != '1) pass_count <= pass_count + 1'b1;
        if (p_fail && fail_count != '1) fail_count <= fail_count + 1'b1;
        if (p_fail && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx <= p_idx;
          first_fail_exp <= p_exp;
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed and randomized runs checked against a vector-list model
module tb_gate_response_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [15:0] num_vectors = '0, a = '0, b = '0, dut_result = '0;
  logic [2:0] op = '0;
  logic in_ready, busy, done, first_fail_valid;
  logic [15:0] pass_count, fail_count, first_fail_idx, first_fail_exp;
  int total = 0, bad = 0;
  logic [2:0] v_op[32];
  logic [15:0] v_a[32], v_b[32], v_d[32];
  bit pat[5] = '{1, 0, 0, 1, 1};

  gate_response_checker #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .dut_result(dut_result), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .first_fail_exp(first_fail_exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gate_fn(input int o, input logic [15:0] x, input logic [15:0] y);
    case (o)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x ^ y);
      4: return ~(x & y);
      5: return ~(x | y);
      6: return ~x;
      default: return 16'h0;
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass_count, 0);
    chk({tag, ".fail"}, fail_count, 0);
    chk({tag, ".ffv"}, first_fail_valid, 0);
    chk({tag, ".ffidx"}, first_fail_idx, 0);
    chk({tag, ".ffexp"}, first_fail_exp, 0);
  endtask

  task automatic fill_rand(input int n, input int err_pct);
    for (int i = 0; i < n; i++) begin
      v_op[i] = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      v_a[i] = 16'($urandom);
      v_b[i] = 16'($urandom);
      v_d[i] = gate_fn(v_op[i], v_a[i], v_b[i]);
      if (v_op[i] == 3'd7) v_d[i] = 16'($urandom_range(0, 3));
      else if ($urandom_range(0, 99) < err_pct) v_d[i] ^= 16'(1 << $urandom_range(0, 15));
    end
  endtask

  // mode 0: always valid; 1: random bubbles and stray starts; 2: valid pattern 1,0,0,1,1 plus a stray start
  task automatic run_check(input string tag, input int n, input int mode);
    int m_pass = 0, m_fail = 0, m_idx = 0, i = 0, cyc = 0;
    logic [15:0] m_exp = '0;
    bit m_ffv = 0;
    for (int k = 0; k < n; k++) begin
      if (v_op[k] != 3'd7 && v_d[k] == gate_fn(v_op[k], v_a[k], v_b[k])) m_pass++;
      else begin
        m_fail++;
        if (!m_ffv) begin
          m_ffv = 1;
          m_idx = k;
          m_exp = gate_fn(v_op[k], v_a[k], v_b[k]);
        end
      end
    end
    @(negedge clk);
    start = 1'b1;
    num_vectors = 16'(n);
    in_valid = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".done_now"}, done, 1);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".pass"}, pass_count, 0);
      chk({tag, ".fail"}, fail_count, 0);
      return;
    end
    while (i < n && cyc < 400) begin
      @(negedge clk);
      start = (mode == 1 && $urandom_range(0, 3) == 0) || (mode == 2 && cyc == 1);
      num_vectors = 16'($urandom);
      in_valid = mode == 0 ? 1'b1 : mode == 2 ? (cyc < 5 ? pat[cyc] : 1'b1) : ($urandom_range(0, 2) != 0);
      op = v_op[i];
      a = v_a[i];
      b = v_b[i];
      dut_result = v_d[i];
      if (in_valid && in_ready) i++;
      cyc++;
    end
    chk({tag, ".xfers"}, i, n);
    if (mode == 2) chk({tag, ".cycles"}, cyc, 5);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    op = 3'd0;
    a = 16'hFFFF;
    b = 16'hFFFF;
    dut_result = 16'h0;
    chk({tag, ".drain_busy"}, busy, 1);
    chk({tag, ".drain_ready"}, in_ready, 0);
    chk({tag, ".drain_done"}, done, 0);
    chk({tag, ".drain_tally"}, pass_count + fail_count, n - 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".pass"}, pass_count, m_pass);
    chk({tag, ".fail"}, fail_count, m_fail);
    chk({tag, ".ffv"}, first_fail_valid, m_ffv);
    if (m_ffv) begin
      chk({tag, ".ffidx"}, first_fail_idx, m_idx);
      chk({tag, ".ffexp"}, first_fail_exp, m_exp);
    end
    @(negedge clk);
    chk({tag, ".hold"}, done, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");
    in_valid = 1'b1;
    op = 3'd0;
    repeat (3) @(negedge clk);
    check_idle_zero("idle_valid");
    in_valid = 1'b0;

    v_op[0] = 3'd3; v_a[0] = 16'h1082; v_b[0] = 16'h1082; v_d[0] = 16'hFFFF;
    v_op[1] = 3'd3; v_a[1] = 16'h4648; v_b[1] = 16'h1082; v_d[1] = 16'hA935;
    v_op[2] = 3'd0; v_a[2] = 16'hA4F1; v_b[2] = 16'h1082; v_d[2] = 16'h0080;
    run_check("dir_pass", 3, 0);
    v_d[1] = 16'hA834;
    run_check("dir_fail", 3, 0);
    v_d[1] = 16'hA935;
    run_check("bubbles", 3, 2);
    run_check("zero", 0, 0);
    v_op[1] = 3'd7; v_a[1] = 16'h1234; v_b[1] = 16'h5678; v_d[1] = 16'h0000;
    run_check("rsvd", 3, 0);

    fill_rand(5, 0);
    @(negedge clk);
    start = 1'b1;
    num_vectors = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      op = v_op[k];
      a = v_a[k];
      b = v_b[k];
      dut_result = v_d[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("mid_reset");
    run_check("after_reset", 5, 1);

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 32);
      fill_rand(n, 20);
      run_check($sformatf("rand%0d", r), n, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
